// File: rtl/inst_loader_pkg.sv
// Shared defaults and state encoding for the instruction-memory loader.
// The optional trailing-checksum state is used only when INST_LOADER_CHECKSUM_EN is defined.
package inst_loader_pkg;

    localparam int WORD_SIZE_DEF     = 32;
    localparam int INST_MEM_SIZE_DEF = 256;
    localparam int ADDR_W_DEF        = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_CHECK  = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERROR  = 3'd7
    } state_t;

    // States in which the loader is listening to the byte stream.
    function automatic logic accepts_byte(input state_t st);
        return (st == ST_LEN_HI) || (st == ST_LEN_LO) || (st == ST_DATA) || (st == ST_CHECK);
    endfunction

endpackage

// File: rtl/inst_loader.sv
// Instruction memory writer: length-prefixed big-endian byte stream -> sequential word writes.
// Define INST_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int WORD_SIZE     = WORD_SIZE_DEF,
    parameter int INST_MEM_SIZE = INST_MEM_SIZE_DEF,
    parameter int ADDR_W        = ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    output logic                 busy,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 error
);
    localparam logic [15:0] MAX_LEN = 16'(INST_MEM_SIZE);

    state_t               state_q, state_d;
    logic [15:0]          len_q, len_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [1:0]           idx_q, idx_d;
    logic [WORD_SIZE-9:0] shift_q, shift_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]           csum_q, csum_d;
`endif

    logic        xfer;
    logic [15:0] len_rx;
    logic [15:0] cnt_inc;

    assign byte_ready = accepts_byte(state_q);
    assign xfer       = byte_valid && byte_ready;
    assign len_rx     = {len_q[15:8], byte_in};
    assign cnt_inc    = cnt_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
`ifdef INST_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_LEN_HI;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    len_d   = '0;
                    cnt_d   = '0;
                    idx_d   = '0;
`ifdef INST_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    len_d   = {byte_in, 8'h00};
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    len_d = len_rx;
                    if (len_rx == 16'd0) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (len_rx > MAX_LEN) begin
                        state_d = ST_ERROR;
                        busy_d  = 1'b0;
                        error_d = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    shift_d = {shift_q[WORD_SIZE-17:0], byte_in};
                    idx_d   = idx_q + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ byte_in;
`endif
                    // Registered write strobe lines up with the single WRITE cycle.
                    if (idx_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = ADDR_W'(cnt_q);
                        mem_wdata_d = {shift_q, byte_in};
                        state_d     = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                cnt_d = cnt_inc;
                if (cnt_inc == len_q) begin
`ifdef INST_LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`endif
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef INST_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (xfer) begin
                    busy_d = 1'b0;
                    if (byte_in == csum_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef INST_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign cpu_hold  = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: normal, zero-length, overflow, stalled, full-depth and reset-abort loads.
// Checksum cases are compiled when INST_LOADER_CHECKSUM_EN is defined.
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    inst_loader #(
        .WORD_SIZE    (32),
        .INST_MEM_SIZE(256),
        .ADDR_W       (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    // Write log and WRITE-cycle ready monitor.
    int          nwr = 0;
    int          ready_viol = 0;
    logic [7:0]  wr_addr [0:1023];
    logic [31:0] wr_data [0:1023];

    always @(negedge clk) begin
        if (rst && mem_we) begin
            if (nwr < 1024) begin
                wr_addr[nwr] = mem_addr;
                wr_data[nwr] = mem_wdata;
            end
            if (byte_ready) ready_viol++;
            nwr++;
        end
    end

    bit         stall_en = 1'b0;
    logic [7:0] csum;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        byte_in = b;
        for (int i = 0; i < 64 && !got; i++) begin
            byte_valid = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            got = byte_valid && byte_ready;
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $error("FAIL send_byte: byte %h not accepted within 64 cycles, required acceptance", b);
        end
    endtask

    task automatic send_len(input logic [15:0] n);
        send_byte(n[15:8]);
        send_byte(n[7:0]);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) begin
            csum = csum ^ w[k*8 +: 8];
            send_byte(w[k*8 +: 8]);
        end
    endtask

    task automatic send_trailer();
`ifdef INST_LOADER_CHECKSUM_EN
        send_byte(csum);
`endif
    endtask

    task automatic wait_end();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done || error) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $error("FAIL wait_end: done/error not seen within 20 cycles, required one of them high");
        end
    endtask

    task automatic load_two(input string tag);
        int base;
        base = nwr;
        csum = 8'h00;
        pulse_start();
        chk({tag, "_busy_on_start"}, {30'd0, busy, cpu_hold}, 32'h3);
        chk({tag, "_flags_cleared"}, {30'd0, done, error}, 32'h0);
        send_len(16'd2);
        send_word(32'h20080005);
        send_word(32'hAC080000);
        send_trailer();
        wait_end();
        chk({tag, "_nwrites"}, nwr - base, 32'd2);
        chk({tag, "_addr0"}, {24'd0, wr_addr[base]}, 32'd0);
        chk({tag, "_data0"}, wr_data[base], 32'h20080005);
        chk({tag, "_addr1"}, {24'd0, wr_addr[base+1]}, 32'd1);
        chk({tag, "_data1"}, wr_data[base+1], 32'hAC080000);
        chk({tag, "_done_busy_hold_err"}, {28'd0, done, busy, cpu_hold, error}, 32'h8);
    endtask

    initial begin
        int base;
        rst        = 1'b0;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        csum       = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {26'd0, busy, cpu_hold, done, error, mem_we, byte_ready}, 32'h0);
        chk("reset_addr", {24'd0, mem_addr}, 32'h0);
        chk("reset_wdata", mem_wdata, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_not_ready", {31'd0, byte_ready}, 32'h0);

        // Two-word load, with first-write latency check.
        base = nwr;
        csum = 8'h00;
        pulse_start();
        send_len(16'd2);
        send_word(32'h20080005);
        chk("lat_we", {31'd0, mem_we}, 32'h1);
        chk("lat_addr", {24'd0, mem_addr}, 32'h0);
        chk("lat_wdata", mem_wdata, 32'h20080005);
        chk("lat_ready_low", {31'd0, byte_ready}, 32'h0);
        send_word(32'hAC080000);
        send_trailer();
        wait_end();
        chk("two_nwrites", nwr - base, 32'd2);
        chk("two_data1", wr_data[base+1], 32'hAC080000);
        chk("two_addr1", {24'd0, wr_addr[base+1]}, 32'd1);
        chk("two_end_flags", {28'd0, done, busy, cpu_hold, error}, 32'h8);
        chk("two_hold_wdata", mem_wdata, 32'hAC080000);
        chk("done_not_ready", {31'd0, byte_ready}, 32'h0);

        // Zero length: straight to DONE, no writes.
        base = nwr;
        pulse_start();
        chk("zero_done_cleared", {31'd0, done}, 32'h0);
        send_len(16'd0);
        chk("zero_done", {29'd0, done, busy, error}, 32'h4);
        byte_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("zero_no_accept", {31'd0, byte_ready}, 32'h0);
        byte_valid = 1'b0;
        chk("zero_nwrites", nwr - base, 32'd0);

        // Overflow: N = 257 > 256.
        base = nwr;
        pulse_start();
        send_len(16'd257);
        chk("ovf_error", {29'd0, error, busy, done}, 32'h4);
        chk("ovf_nwrites", nwr - base, 32'd0);
        chk("ovf_not_ready", {31'd0, byte_ready}, 32'h0);

        // Stalled stream produces the same writes.
        stall_en = 1'b1;
        load_two("stall");
        stall_en = 1'b0;
        chk("stall_ready_in_write", ready_viol, 32'd0);

        // Full depth: N = 256, last address 255, no wrap.
        base = nwr;
        csum = 8'h00;
        pulse_start();
        send_len(16'd256);
        for (int i = 0; i < 256; i++)
            send_word({8'hA5, 8'(i), 8'h5A, ~8'(i)});
        send_trailer();
        wait_end();
        chk("full_nwrites", nwr - base, 32'd256);
        chk("full_first", wr_data[base], 32'hA5005AFF);
        chk("full_last_addr", {24'd0, wr_addr[base+255]}, 32'd255);
        chk("full_last_data", wr_data[base+255], 32'hA5FF5A00);
        chk("full_done", {30'd0, done, error}, 32'h2);

        // Reset after the 6th byte: outputs drop immediately.
        csum = 8'h00;
        pulse_start();
        send_len(16'd2);
        send_word(32'h20080005);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_mid_ctrl", {26'd0, busy, cpu_hold, done, error, mem_we, byte_ready}, 32'h0);
        chk("rst_mid_addr_wdata", mem_wdata | {24'd0, mem_addr}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        load_two("after_rst");

`ifdef INST_LOADER_CHECKSUM_EN
        base = nwr;
        pulse_start();
        send_len(16'd1);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        send_byte(8'h08);
        wait_end();
        chk("csum_ok_flags", {30'd0, done, error}, 32'h2);
        chk("csum_ok_data", wr_data[base], 32'h12345678);
        pulse_start();
        send_len(16'd1);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        send_byte(8'h09);
        wait_end();
        chk("csum_bad_flags", {30'd0, done, error}, 32'h1);
        chk("csum_bad_nwrites", nwr - base, 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
